// File: rtl/qpsk_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : qpsk_phase_sequencer
// Brief    : Bring-up sequencer for the QPSK datapath. Resets the datapath,
//            lets it settle, sweeps the receiver sampling phase while counting
//            bit errors over a fixed symbol window, then locks the best phase.
// Config   : QPSK_PHASE_SWEEP_EN - defined: sweep all N_PHASES phases;
//            undefined: single measurement pass at i_phase_fix.
// Revision : 1.0 - initial release
// ============================================================================
module qpsk_phase_sequencer #(
    parameter int N_PHASES      = 4,
    parameter int PHASE_W       = 2,
    parameter int WINDOW_LEN    = 1024,
    parameter int SETTLE_CYCLES = 256,
    parameter int ERR_W         = 16
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_sym_valid,
    input  logic [1:0]         i_bit_err,
    input  logic [ERR_W-1:0]   i_err_thr,
    input  logic [PHASE_W-1:0] i_phase_fix,
    output logic               o_dp_reset,
    output logic               o_dp_enable,
    output logic [PHASE_W-1:0] o_phase,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_locked,
    output logic [ERR_W-1:0]   o_min_err,
    output logic [2:0]         o_state
);

    // Shared cycle counter covers both the 4-cycle datapath reset and settling
    localparam int c_CNT_W       = $clog2((SETTLE_CYCLES > 4) ? SETTLE_CYCLES : 4) + 1;
    localparam int c_SYM_W       = $clog2(WINDOW_LEN + 1);
    localparam int c_DP_RST_LEN  = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DP_RST  = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_MEASURE = 3'd3,
        ST_EVAL    = 3'd4,
        ST_LOCK    = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic [c_SYM_W-1:0]   r_sym_cnt;
    logic [c_SYM_W-1:0]   w_sym_cnt_nxt;
    logic [ERR_W-1:0]     r_err_acc;
    logic [ERR_W-1:0]     w_err_acc_nxt;
    logic [ERR_W-1:0]     r_best_err;
    logic [ERR_W-1:0]     w_best_err_nxt;
    logic [PHASE_W-1:0]   r_phase;
    logic [PHASE_W-1:0]   w_phase_nxt;
    logic [PHASE_W-1:0]   r_best_phase;
    logic [PHASE_W-1:0]   w_best_phase_nxt;

    logic [1:0]           w_popcnt;
    logic [ERR_W:0]       w_acc_sum;
    logic [ERR_W-1:0]     w_acc_sat;

`ifndef QPSK_PHASE_SWEEP_EN
`else
    // Fixed phase input is not used when the full sweep is built in
    logic                 w_unused_phase_fix;
    assign w_unused_phase_fix = ^i_phase_fix;
`endif

    // Error accumulation adds 0, 1 or 2 per symbol and clamps at all-ones
    assign w_popcnt  = {1'b0, i_bit_err[1]} + {1'b0, i_bit_err[0]};
    assign w_acc_sum = {1'b0, r_err_acc} + {{(ERR_W-1){1'b0}}, w_popcnt};
    assign w_acc_sat = w_acc_sum[ERR_W] ? {ERR_W{1'b1}} : w_acc_sum[ERR_W-1:0];

    // State register
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-value logic for the sweep bookkeeping
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_sym_cnt_nxt    = r_sym_cnt;
        w_err_acc_nxt    = r_err_acc;
        w_best_err_nxt   = r_best_err;
        w_phase_nxt      = r_phase;
        w_best_phase_nxt = r_best_phase;

        case (r_state)
            ST_IDLE, ST_LOCK: begin
                if (i_start) begin
                    w_state_nxt    = ST_DP_RST;
                    w_cnt_nxt      = '0;
                    w_best_err_nxt = {ERR_W{1'b1}};
`ifdef QPSK_PHASE_SWEEP_EN
                    w_phase_nxt      = '0;
                    w_best_phase_nxt = '0;
`else
                    w_phase_nxt      = i_phase_fix;
                    w_best_phase_nxt = i_phase_fix;
`endif
                end
            end

            ST_DP_RST: begin
                if (r_cnt == c_CNT_W'(c_DP_RST_LEN - 1)) begin
                    w_state_nxt = ST_SETTLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            ST_SETTLE: begin
                if (r_cnt == c_CNT_W'(SETTLE_CYCLES - 1)) begin
                    w_state_nxt   = ST_MEASURE;
                    w_cnt_nxt     = '0;
                    w_err_acc_nxt = '0;
                    w_sym_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            ST_MEASURE: begin
                if (i_sym_valid) begin
                    w_err_acc_nxt = w_acc_sat;
                    w_sym_cnt_nxt = r_sym_cnt + 1'b1;
                    if (r_sym_cnt == c_SYM_W'(WINDOW_LEN - 1)) begin
                        w_state_nxt = ST_EVAL;
                    end
                end
            end

            ST_EVAL: begin
                // Strict compare so a tie keeps the earlier phase
                if (r_err_acc < r_best_err) begin
                    w_best_err_nxt   = r_err_acc;
                    w_best_phase_nxt = r_phase;
                end
`ifdef QPSK_PHASE_SWEEP_EN
                if (r_phase == PHASE_W'(N_PHASES - 1)) begin
                    w_state_nxt = ST_LOCK;
                end else begin
                    w_state_nxt = ST_SETTLE;
                    w_phase_nxt = r_phase + 1'b1;
                    w_cnt_nxt   = '0;
                end
`else
                w_state_nxt = ST_LOCK;
`endif
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Bookkeeping registers and outputs, registered from next-state values
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_cnt        <= '0;
            r_sym_cnt    <= '0;
            r_err_acc    <= '0;
            r_best_err   <= {ERR_W{1'b1}};
            r_phase      <= '0;
            r_best_phase <= '0;
            o_dp_reset   <= 1'b1;
            o_dp_enable  <= 1'b0;
            o_phase      <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_locked     <= 1'b0;
            o_min_err    <= {ERR_W{1'b1}};
            o_state      <= 3'd0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_sym_cnt    <= w_sym_cnt_nxt;
            r_err_acc    <= w_err_acc_nxt;
            r_best_err   <= w_best_err_nxt;
            r_phase      <= w_phase_nxt;
            r_best_phase <= w_best_phase_nxt;
            o_state      <= w_state_nxt;
            o_dp_reset   <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_DP_RST);
            o_dp_enable  <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DP_RST);
            o_busy       <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_LOCK);
            o_done       <= (w_state_nxt == ST_LOCK) && (r_state != ST_LOCK);
            o_locked     <= (w_state_nxt == ST_LOCK) && (w_best_err_nxt <= i_err_thr);
            o_min_err    <= w_best_err_nxt;
            o_phase      <= (w_state_nxt == ST_LOCK) ? w_best_phase_nxt : w_phase_nxt;
        end
    end

endmodule
`default_nettype wire

// File: doc/qpsk_phase_sequencer.md
# qpsk_phase_sequencer

Controller that sequences bring-up of the QPSK communication datapath. On a start request it resets the datapath and lets it settle. It then sweeps the receiver sampling phase, measures bit errors over a fixed symbol window at each phase, and locks the phase with the fewest errors. It sits beside the QPSK system in the top level, and its state and result outputs are exposed to VIO/ILA probes.

## Interface
- `N_PHASES`, 4: number of sampling phases swept, 2..16.
- `PHASE_W`, 2: width of phase select, ≥ clog2(N_PHASES).
- `WINDOW_LEN`, 1024: valid symbols per measurement window, ≥ 1.
- `SETTLE_CYCLES`, 256: clock cycles of settling after reset or a phase change, ≥ 1.
- `ERR_W`, 16: error counter width.

Ports:
- `clk`  in  1  system clock.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_start`  in  1  start request (level or pulse); sampled in IDLE and LOCK only.
- `i_sym_valid`  in  1  symbol strobe from the datapath BER checker.
- `i_bit_err`  in  2  per-symbol error flags {Q,I}; qualified by `i_sym_valid`.
- `i_err_thr`  in  ERR_W  lock threshold.
- `i_phase_fix`  in  PHASE_W  phase used when the sweep is compiled out.
- `o_dp_reset`  out  1  active-high reset to the datapath.
- `o_dp_enable`  out  1  datapath enable.
- `o_phase`  out  PHASE_W  sampling phase applied to the receiver.
- `o_busy`  out  1  high in any state except IDLE and LOCK.
- `o_done`  out  1  one-cycle pulse on entry to LOCK.
- `o_locked`  out  1  in LOCK and `o_min_err <= i_err_thr`.
- `o_min_err`  out  ERR_W  best error count found.
- `o_state`  out  3  encoded state for probing.

## Operation
- States and encodings: IDLE=0, DP_RST=1, SETTLE=2, MEASURE=3, EVAL=4, LOCK=5.
- **IDLE.** `i_start` starts a sweep. On start: phase = 0, best_err = all-ones, best_phase = 0. Next state DP_RST.
- **DP_RST.** `o_dp_reset`=1 and `o_dp_enable`=0 for exactly 4 cycles, then SETTLE.
- **SETTLE.** `o_dp_enable`=1. Count SETTLE_CYCLES cycles, then MEASURE with the error accumulator and symbol counter cleared.
- **MEASURE.** On each `i_sym_valid`:
  - err_acc += popcount(`i_bit_err`) (adds 0, 1 or 2), saturating at 2^ERR_W−1.
  - sym_cnt += 1.
  - When sym_cnt reaches WINDOW_LEN, go to EVAL.
  - Cycles without `i_sym_valid` do not advance the counters; there is no timeout.
- **EVAL.** One cycle.
  - If err_acc < best_err (strict compare; ties keep the earlier phase): best_err = err_acc and best_phase = phase.
  - If phase == N_PHASES−1: go to LOCK.
  - Otherwise: phase += 1 and go to SETTLE.
- **LOCK.**
  - `o_phase` = best_phase, `o_min_err` = best_err, `o_dp_enable`=1.
  - `i_start` restarts the full sequence from DP_RST.
- During IDLE through EVAL, `o_phase` shows the phase under test.
- `i_start` is ignored in DP_RST through EVAL.
- Reset mid-operation: the state machine returns to IDLE within one cycle and all outputs take their reset values. Partial results are discarded.

## Timing
- All outputs are registered and change on the clock edge after the state transition.
- Reset values:
  - `o_dp_reset`=1, so the datapath is held in reset while the sequencer is in reset and in IDLE.
  - `o_dp_enable`=0, `o_phase`=0, `o_busy`=0, `o_done`=0, `o_locked`=0.
  - `o_min_err`=all-ones, `o_state`=0.
- Start latency: `i_start` high at edge k puts the state in DP_RST after edge k, so `o_busy`=1 from cycle k+1.
- Per-phase duration with continuous `i_sym_valid`: SETTLE_CYCLES + WINDOW_LEN + 1 cycles.
- Total sweep: 4 + N_PHASES·(SETTLE_CYCLES + WINDOW_LEN + 1) cycles from DP_RST entry to LOCK entry.
- `o_done` is high for exactly the first LOCK cycle.
- `o_locked` is combinationally registered from `i_err_thr`: a threshold change while in LOCK updates `o_locked` one cycle later.

## Configuration
- Macro: `QPSK_PHASE_SWEEP_EN`.
- Defined: full sweep over N_PHASES as described above.
- Undefined:
  - A single SETTLE/MEASURE/EVAL pass runs at phase `i_phase_fix`, then LOCK.
  - best_phase = `i_phase_fix`.
  - `o_phase` follows `i_phase_fix` (sampled at start) in all non-IDLE states.

## Test plan
- **Sweep selects the phase with fewest errors.** N_PHASES=4, WINDOW_LEN=8, SETTLE_CYCLES=4, `i_sym_valid` continuously high, per-phase errors 5,1,3,7 → LOCK with `o_phase`=1 and `o_min_err`=1. `o_done` pulses once, at cycle 4+4·13=56 after DP_RST entry.
- **Tie and saturation.** Per-phase errors 2,2,2,2 → `o_phase`=0. ERR_W=4 with `i_bit_err`=2'b11 on every symbol, WINDOW_LEN=16 → err_acc saturates at 15.
- **Gapped valid.** `i_sym_valid` every third cycle, WINDOW_LEN=8 → MEASURE lasts 22–24 cycles and each error total is counted exactly once.
- **Lock threshold.** Lock with `o_min_err`=3: `i_err_thr`=2 → `o_locked`=0; change to 3 → `o_locked`=1 on the next cycle.
- **Reset mid-MEASURE.** Assert `i_reset` for one cycle at phase 2 → next cycle `o_state`=0, `o_dp_reset`=1, `o_busy`=0, `o_min_err`=all-ones. `i_start` held high during the sweep causes no restart until LOCK.
- **Sweep compiled out.** `QPSK_PHASE_SWEEP_EN` undefined, `i_phase_fix`=3 → one window only, LOCK at cycle 4+13=17 with `o_phase`=3.
